// File: rtl/modulo_io_param.sv
// -----------------------------------------------------------------------------
// modulo_io_param
//   I/O unit of the single-cycle core. It serves the IN, OUT and HALT
//   instructions:
//     IN   - freezes the PC (Halt) until the operator confirms with Set, then
//            returns the switch value on DataIO for one completing cycle.
//     OUT  - writes one of N_OUT output channel registers and pulses OutValid.
//     HALT - freezes the PC until reset.
//   Set is synchronised with two flops and then debounced before its rising
//   edge is used.
//
//   Build option:
//     IO_SIGN_EXT_EN  defined     : DataIO = Switches sign-extended from SW_W-1
//                     not defined : DataIO = Switches zero-extended
// -----------------------------------------------------------------------------
module modulo_io_param #(
    parameter int DATA_W       = 32,  // datapath width
    parameter int SW_W         = 13,  // board switches, <= DATA_W
    parameter int N_OUT        = 4,   // output channels, 1..8
    parameter int DEBOUNCE_CYC = 4    // equal samples needed to flip Set, >= 1
) (
    input  logic                    Clock,
    input  logic                    Reset,     // asynchronous, active-low
    input  logic [SW_W-1:0]         Switches,  // asynchronous to Clock
    input  logic                    Set,       // asynchronous, active-high
    input  logic [1:0]              OpIO,      // 00 none, 01 IN, 10 OUT, 11 HALT
    input  logic [2:0]              Channel,   // OUT target channel
    input  logic [DATA_W-1:0]       DataIn,    // OUT data
    output logic                    Halt,      // freezes the PC while 1
    output logic [DATA_W-1:0]       DataIO,    // IN result
    output logic [N_OUT*DATA_W-1:0] OutData,   // channel k at [k*DATA_W +: DATA_W]
    output logic [N_OUT-1:0]        OutValid,  // one-cycle write pulse per channel
    output logic                    ChErr      // sticky: OUT to a missing channel
);

    // FSM encoding kept as plain constants for compatibility with older tools.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SET = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_IN   = 2'b01;
    localparam logic [1:0] OP_OUT  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    // The debounce counter counts differing samples already seen, 0..DEBOUNCE_CYC-1.
    localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]       N_OUT_L  = 4'(N_OUT);

    // ------------------------------------------------------------------
    // Set input conditioning
    // ------------------------------------------------------------------
    logic             set_meta;
    logic             set_sync;
    logic             set_deb;
    logic             set_deb_d;
    logic [CNT_W-1:0] deb_cnt;
    logic             set_rise;

    // Two-flop synchroniser for the asynchronous Set button.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            set_meta <= 1'b0;
            set_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make set_sync take the previous
            // set_meta, giving a real two-stage chain instead of one flop.
            set_meta <= Set;
            set_sync <= set_meta;
        end
    end

    // Debouncer: the debounced level flips only after DEBOUNCE_CYC
    // consecutive synchronised samples disagree with it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            set_deb   <= 1'b0;
            set_deb_d <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            set_deb_d <= set_deb;
            if (set_sync != set_deb) begin
                if (deb_cnt == CNT_LAST) begin
                    set_deb <= set_sync;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                // A single agreeing sample restarts the count.
                deb_cnt <= '0;
            end
        end
    end

    // One-cycle pulse on the debounced rising edge; a held button cannot re-fire.
    assign set_rise = set_deb & ~set_deb_d;

    // ------------------------------------------------------------------
    // Switch extension
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sw_ext;

    // Widen the switch value to the datapath; the operator sets the switches
    // before pressing Set, so they are stable when captured.
    always_comb begin
`ifdef IO_SIGN_EXT_EN
        sw_ext = {DATA_W{Switches[SW_W-1]}};
`else
        sw_ext = '0;
`endif
        sw_ext[SW_W-1:0] = Switches;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       out_wr;
    logic       ch_err_set;
    logic       capture;
    logic       halt_raw;
    logic       ch_ok;

    assign ch_ok = ({1'b0, Channel} < N_OUT_L);

    // Next-state and action decode; OpIO is only acted on in IDLE.
    always_comb begin
        // NOTE: every signal of this block gets a default first, so paths that
        // do not mention it cannot infer a latch.
        state_nxt  = state;
        out_wr     = 1'b0;
        ch_err_set = 1'b0;
        capture    = 1'b0;
        halt_raw   = 1'b0;
        case (state)
            ST_IDLE: begin
                case (OpIO)
                    OP_NONE: ;
                    OP_IN: begin
                        halt_raw  = 1'b1;
                        state_nxt = ST_WAIT_SET;
                    end
                    OP_OUT: begin
                        if (ch_ok) out_wr     = 1'b1;
                        else       ch_err_set = 1'b1;
                    end
                    OP_HALT: begin
                        halt_raw  = 1'b1;
                        state_nxt = ST_HALTED;
                    end
                    default: ;
                endcase
            end
            ST_WAIT_SET: begin
                // The IN instruction is held by the frozen PC; wait for the operator.
                halt_raw = 1'b1;
                if (set_rise) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Single released cycle in which the IN writes DataIO back.
                state_nxt = ST_IDLE;
            end
            ST_HALTED: begin
                halt_raw = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Halt drops together with Reset, even while the IN opcode is still driven.
    assign Halt = Reset & halt_raw;

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // IN result register; holds until the next capture.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)       DataIO <= '0;
        else if (capture) DataIO <= sw_ext;
    end

    // Sticky channel-range error.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)          ChErr <= 1'b0;
        else if (ch_err_set) ChErr <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Output channels
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ch_reg [N_OUT];

    // Channel registers, written by OUT and held until rewritten.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            // NOTE: the channel registers are cleared individually because
            // OutData must read zero out of reset; they cannot become a RAM.
            for (int k = 0; k < N_OUT; k++) ch_reg[k] <= '0;
        end else if (out_wr) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (Channel == 3'(k)) ch_reg[k] <= DataIn;
            end
        end
    end

    // Write strobe for the display side, high for the cycle after the write.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            OutValid <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) OutValid[k] <= out_wr && (Channel == 3'(k));
        end
    end

    // Flatten the channel registers onto the output bus.
    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign OutData[g*DATA_W +: DATA_W] = ch_reg[g];
    end

endmodule

// File: tb/tb_modulo_io_param.sv
// -----------------------------------------------------------------------------
// tb_modulo_io_param
//   Self-checking bench for modulo_io_param with default parameters. A
//   behavioural model (sample history queues and transaction flags) predicts
//   every output each cycle; a vector table and directed sequences add fixed
//   expected values. Follows IO_SIGN_EXT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_modulo_io_param;

    localparam int DATA_W = 32;
    localparam int SW_W   = 13;
    localparam int N_OUT  = 4;
    localparam int DEB    = 4;

`ifdef IO_SIGN_EXT_EN
    localparam logic [DATA_W-1:0] T6_EXP = 32'hFFFFF000;
`else
    localparam logic [DATA_W-1:0] T6_EXP = 32'h00001000;
`endif

    logic                    Clock = 1'b0;
    logic                    Reset;
    logic [SW_W-1:0]         Switches;
    logic                    Set;
    logic [1:0]              OpIO;
    logic [2:0]              Channel;
    logic [DATA_W-1:0]       DataIn;
    logic                    Halt;
    logic [DATA_W-1:0]       DataIO;
    logic [N_OUT*DATA_W-1:0] OutData;
    logic [N_OUT-1:0]        OutValid;
    logic                    ChErr;

    int n_checks = 0;
    int n_fail   = 0;

    modulo_io_param #(
        .DATA_W(DATA_W), .SW_W(SW_W), .N_OUT(N_OUT), .DEBOUNCE_CYC(DEB)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Switches(Switches), .Set(Set),
        .OpIO(OpIO), .Channel(Channel), .DataIn(DataIn), .Halt(Halt),
        .DataIO(DataIO), .OutData(OutData), .OutValid(OutValid), .ChErr(ChErr)
    );

    initial forever #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    bit                    m_wait, m_done, m_halted, m_cherr;
    logic [DATA_W-1:0]     m_dataio;
    logic [N_OUT*DATA_W-1:0] m_out;
    logic [N_OUT-1:0]      m_valid;
    bit                    raw_q[$];   // Set as seen at each rising edge
    bit                    sq[$];      // last DEB synchronised samples
    bit                    m_deb, m_deb_prev;

    function automatic logic [DATA_W-1:0] ext_sw(input logic [SW_W-1:0] sw);
`ifdef IO_SIGN_EXT_EN
        logic signed [DATA_W-1:0] t;
        t = $signed(sw);
        return t;
`else
        return DATA_W'(sw);
`endif
    endfunction

    task automatic reset_model();
        m_wait = 0; m_done = 0; m_halted = 0; m_cherr = 0;
        m_dataio = '0; m_out = '0; m_valid = '0;
        raw_q.delete(); sq.delete();
        m_deb = 0; m_deb_prev = 0;
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_edge();
        bit rise, x, all_diff;
        if (!Reset) begin
            reset_model();
            return;
        end
        rise = m_deb && !m_deb_prev;
        // The debouncer sees Set as it was two edges ago.
        x = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
        raw_q.push_back(Set);
        if (raw_q.size() > 4) void'(raw_q.pop_front());
        sq.push_back(x);
        if (sq.size() > DEB) void'(sq.pop_front());
        m_deb_prev = m_deb;
        if (sq.size() == DEB) begin
            all_diff = 1;
            foreach (sq[i]) if (sq[i] == m_deb) all_diff = 0;
            if (all_diff) m_deb = !m_deb;
        end
        m_valid = '0;
        if (m_halted) begin
        end else if (m_wait) begin
            if (rise) begin
                m_dataio = ext_sw(Switches);
                m_wait   = 0;
                m_done   = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else begin
            if (OpIO == 2'b01) m_wait = 1;
            else if (OpIO == 2'b11) m_halted = 1;
            else if (OpIO == 2'b10) begin
                if (Channel < N_OUT) begin
                    m_out[Channel*DATA_W +: DATA_W] = DataIn;
                    m_valid[Channel] = 1'b1;
                end else begin
                    m_cherr = 1;
                end
            end
        end
    endtask

    function automatic logic exp_halt();
        return Reset && (m_halted || m_wait ||
                         (!m_done && (OpIO == 2'b01 || OpIO == 2'b11)));
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag);
        check({tag, "_halt"},     Halt,     exp_halt());
        check({tag, "_dataio"},   DataIO,   m_dataio);
        check({tag, "_outdata"},  OutData,  m_out);
        check({tag, "_outvalid"}, OutValid, m_valid);
        check({tag, "_cherr"},    ChErr,    m_cherr);
    endtask

    // Rising edge, model update, then step off the edge.
    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        repeat (n) begin
            tick();
            #1;
            cmp_all(tag);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        reset_model();
        OpIO = 2'b00; Set = 1'b0; Channel = '0; DataIn = '0; Switches = '0;
        #1;
        cmp_all("do_reset");
        tick();
        tick();
        Reset = 1'b1;
        #1;
        cmp_all("do_reset_rel");
    endtask

    // ------------------------------------------------------------------
    // Vector table for OUT handling
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]        op;
        logic [2:0]        ch;
        logic [DATA_W-1:0] din;
        logic              exp_halt;
        logic [N_OUT-1:0]  exp_valid;
        logic              exp_cherr;
        logic [2:0]        chk_ch;
        logic [DATA_W-1:0] exp_word;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int run_left;
        int r;

        vecs[0] = '{2'b10, 3'd2, 32'hDEADBEEF, 1'b0, 4'b0100, 1'b0, 3'd2, 32'hDEADBEEF};
        vecs[1] = '{2'b10, 3'd5, 32'h12345678, 1'b0, 4'b0000, 1'b1, 3'd2, 32'hDEADBEEF};
        vecs[2] = '{2'b10, 3'd0, 32'h00000001, 1'b0, 4'b0001, 1'b1, 3'd0, 32'h00000001};
        vecs[3] = '{2'b10, 3'd3, 32'hA5A5A5A5, 1'b0, 4'b1000, 1'b1, 3'd3, 32'hA5A5A5A5};
        vecs[4] = '{2'b00, 3'd3, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b1, 3'd3, 32'hA5A5A5A5};
        vecs[5] = '{2'b10, 3'd1, 32'hCAFEF00D, 1'b0, 4'b0010, 1'b1, 3'd1, 32'hCAFEF00D};
        vecs[6] = '{2'b10, 3'd7, 32'h00000000, 1'b0, 4'b0000, 1'b1, 3'd0, 32'h00000001};
        vecs[7] = '{2'b10, 3'd2, 32'h00000000, 1'b0, 4'b0100, 1'b1, 3'd2, 32'h00000000};

        Reset = 1'b0; Set = 1'b0; OpIO = 2'b00; Channel = '0; DataIn = '0; Switches = '0;
        reset_model();
        #2;
        check("reset_halt",     Halt,     1'b0);
        check("reset_dataio",   DataIO,   '0);
        check("reset_outdata",  OutData,  '0);
        check("reset_outvalid", OutValid, '0);
        check("reset_cherr",    ChErr,    1'b0);
        tick();
        tick();
        Reset = 1'b1;
        #1;
        cmp_all("release");

        // OUT vectors, including out-of-range channels and a no-op.
        for (int i = 0; i < 8; i++) begin
            OpIO = vecs[i].op; Channel = vecs[i].ch; DataIn = vecs[i].din;
            #1;
            check($sformatf("vec%0d_halt", i), Halt, vecs[i].exp_halt);
            cmp_all("vec_issue");
            tick();
            OpIO = 2'b00;
            #1;
            check($sformatf("vec%0d_valid", i), OutValid, vecs[i].exp_valid);
            check($sformatf("vec%0d_cherr", i), ChErr, vecs[i].exp_cherr);
            check($sformatf("vec%0d_word", i), OutData[vecs[i].chk_ch*DATA_W +: DATA_W], vecs[i].exp_word);
            cmp_all("vec_after");
            tick();
            #1;
            check($sformatf("vec%0d_valid_drop", i), OutValid, '0);
        end

        // IN with a 10-cycle Set pulse.
        OpIO = 2'b01; Switches = 13'h0ABC;
        #1;
        check("t2_halt_issue", Halt, 1'b1);
        cmp_all("t2_issue");
        tick();
        Set = 1'b1;
        #1;
        cmp_all("t2_press");
        for (int i = 1; i <= 7; i++) begin
            tick();
            #1;
            cmp_all("t2_wait");
            if (i < 7) check("t2_halt_wait", Halt, 1'b1);
        end
        check("t2_halt_done", Halt, 1'b0);
        check("t2_dataio", DataIO, 32'h00000ABC);
        OpIO = 2'b00;
        for (int i = 8; i <= 10; i++) begin
            tick();
            #1;
            check("t2_halt_idle", Halt, 1'b0);
            cmp_all("t2_idle");
        end
        Set = 1'b0;
        idle_cycles(10, "t2_settle");

        // Two INs with Set held: the second needs a fresh press.
        OpIO = 2'b01; Switches = 13'h0567; Set = 1'b1;
        #1;
        cmp_all("t3_issue");
        for (int i = 1; i <= 7; i++) begin
            tick();
            #1;
            cmp_all("t3_first");
        end
        check("t3_first_done", Halt, 1'b0);
        check("t3_first_data", DataIO, 32'h00000567);
        Switches = 13'h0765;
        tick();
        #1;
        check("t3_second_issue", Halt, 1'b1);
        repeat (20) begin
            tick();
            #1;
            check("t3_held_no_fire", Halt, 1'b1);
            cmp_all("t3_held");
        end
        Set = 1'b0;
        repeat (8) begin
            tick();
            #1;
            check("t3_release_halt", Halt, 1'b1);
            cmp_all("t3_release");
        end
        Set = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            #1;
            cmp_all("t3_repress");
            if (i < 7) check("t3_repress_halt", Halt, 1'b1);
        end
        check("t3_second_done", Halt, 1'b0);
        check("t3_second_data", DataIO, 32'h00000765);
        OpIO = 2'b00; Set = 1'b0;
        idle_cycles(10, "t3_settle");

        // Short glitch ignored, then a real press captures 13'h1000.
        OpIO = 2'b01; Switches = 13'h1000;
        tick();
        Set = 1'b1;
        repeat (3) begin
            #1;
            cmp_all("t4_glitch");
            tick();
        end
        Set = 1'b0;
        repeat (15) begin
            tick();
            #1;
            check("t4_glitch_halt", Halt, 1'b1);
            cmp_all("t4_after");
        end
        Set = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            #1;
            cmp_all("t6_press");
        end
        check("t6_done", Halt, 1'b0);
        check("t6_dataio_ext", DataIO, T6_EXP);
        OpIO = 2'b00; Set = 1'b0;
        idle_cycles(10, "t6_settle");

        // Reset in the middle of WAIT_SET.
        OpIO = 2'b01;
        tick();
        #1;
        check("t1_wait_halt", Halt, 1'b1);
        Reset = 1'b0;
        reset_model();
        #1;
        check("t1_rst_halt",     Halt,     1'b0);
        check("t1_rst_dataio",   DataIO,   '0);
        check("t1_rst_outdata",  OutData,  '0);
        check("t1_rst_outvalid", OutValid, '0);
        check("t1_rst_cherr",    ChErr,    1'b0);
        OpIO = 2'b00;
        tick();
        tick();
        Reset = 1'b1;
        #1;
        check("t1_idle_halt", Halt, 1'b0);
        cmp_all("t1_rel");
        OpIO = 2'b10; Channel = 3'd1; DataIn = 32'h0BADF00D;
        tick();
        OpIO = 2'b00;
        #1;
        check("t1_out_after_rst", OutValid, 4'b0010);
        cmp_all("t1_out");

        // Randomised traffic against the model, with one reset mid-way.
        run_left = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (c == 300) begin
                Reset = 1'b0;
                reset_model();
            end
            if (c == 303) Reset = 1'b1;
            r = int'($urandom_range(0, 9));
            OpIO     = (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : 2'b01;
            Channel  = 3'($urandom_range(0, 7));
            DataIn   = $urandom;
            Switches = SW_W'($urandom);
            if (run_left == 0) begin
                Set      = !Set;
                run_left = int'($urandom_range(1, 9));
            end else begin
                run_left--;
            end
            #1;
            cmp_all("rnd");
        end

        // HALT is final: Set presses and OUTs have no effect.
        do_reset();
        OpIO = 2'b11;
        #1;
        check("t7_halt_issue", Halt, 1'b1);
        tick();
        OpIO = 2'b10; Channel = 3'd0; DataIn = 32'h00000055;
        #1;
        check("t7_halt_hold", Halt, 1'b1);
        tick();
        #1;
        check("t7_no_valid", OutValid, '0);
        check("t7_no_write", OutData[DATA_W-1:0], '0);
        Set = 1'b1;
        repeat (12) begin
            tick();
            #1;
            check("t7_set_ignored", Halt, 1'b1);
            cmp_all("t7_set");
        end
        Set = 1'b0;
        repeat (10) begin
            tick();
            #1;
            check("t7_still_halted", Halt, 1'b1);
            cmp_all("t7_end");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
